// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported memory/MMIO controller.
// Registers the winner's request onto the memory bus, waits a fixed latency, then acks the winner.
module mem_bus_arbiter #(
    parameter int ADDRESS_BITS = 16,
    parameter int MEMORY_BITS  = 16,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic [ADDRESS_BITS-1:0] addr0,
    input  logic [MEMORY_BITS-1:0]  wdata0,
    input  logic                    we0,
    output logic                    ack0,
    input  logic                    req1,
    input  logic [ADDRESS_BITS-1:0] addr1,
    input  logic [MEMORY_BITS-1:0]  wdata1,
    input  logic                    we1,
    output logic                    ack1,
    output logic [MEMORY_BITS-1:0]  rdata,
    output logic                    grant,
    output logic                    busy,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [MEMORY_BITS-1:0]  mem_wdata,
    output logic                    mem_we,
    output logic                    mem_select,
    input  logic [MEMORY_BITS-1:0]  mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    grant_q, grant_d;
    logic                    last_grant_q, last_grant_d;
    logic                    busy_q, busy_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;
    logic                    sel_q, sel_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [MEMORY_BITS-1:0]  wdata_q, wdata_d;
    logic                    we_q, we_d;
    logic [MEMORY_BITS-1:0]  rdata_q, rdata_d;
    logic                    winner_s;

    // Contention goes to the port that did not win last time; a lone request always wins.
    always_comb begin
        if (req0 && req1) begin
            winner_s = ~last_grant_q;
        end else begin
            winner_s = req1;
        end
    end

    // Next-state logic for the transaction sequencer and all registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        sel_d        = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d      = winner_s;
                    last_grant_d = winner_s;
                    sel_d        = 1'b1;
                    state_d      = ST_ISSUE;
                    if (winner_s) begin
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        we_d    = we1;
                    end else begin
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        we_d    = we0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != {CNT_W{1'b0}}) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_DONE;
                    if (grant_q) begin
                        ack1_d = 1'b1;
                    end else begin
                        ack0_d = 1'b1;
                    end
                    // Writes leave the shared read-data register untouched.
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            sel_q        <= 1'b0;
            addr_q       <= {ADDRESS_BITS{1'b0}};
            wdata_q      <= {MEMORY_BITS{1'b0}};
            we_q         <= 1'b0;
            rdata_q      <= {MEMORY_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign rdata      = rdata_q;
    assign grant      = grant_q;
    assign busy       = busy_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_we     = we_q;
    assign mem_select = sel_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one instance with MEM_LATENCY=1, one with MEM_LATENCY=3.
module tb_mem_bus_arbiter;

    typedef struct {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = 16'h0, wdata0 = 16'h0, addr1 = 16'h0, wdata1 = 16'h0;
    logic [15:0] mem_rdata = 16'h0;
    logic        ack0, ack1, grant, busy, mem_we, mem_select;
    logic [15:0] rdata, mem_addr, mem_wdata;

    logic        b_req0 = 1'b0, b_we0 = 1'b0, b_req1 = 1'b0, b_we1 = 1'b0;
    logic [15:0] b_addr0 = 16'h0, b_wdata0 = 16'h0, b_addr1 = 16'h0, b_wdata1 = 16'h0;
    logic [15:0] b_mem_rdata = 16'h0;
    logic        b_ack0, b_ack1, b_grant, b_busy, b_mem_we, b_mem_select;
    logic [15:0] b_rdata, b_mem_addr, b_mem_wdata;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sel_cnt = 0;
    logic prev_sel = 1'b0;
    exp_t sb_q[$];
    exp_t sb_b[$];

    mem_bus_arbiter #(.ADDRESS_BITS(16), .MEMORY_BITS(16), .MEM_LATENCY(1)) u_a (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .ack1(ack1),
        .rdata(rdata), .grant(grant), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_select(mem_select), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.ADDRESS_BITS(16), .MEMORY_BITS(16), .MEM_LATENCY(3)) u_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .addr0(b_addr0), .wdata0(b_wdata0), .we0(b_we0), .ack0(b_ack0),
        .req1(b_req1), .addr1(b_addr1), .wdata1(b_wdata1), .we1(b_we1), .ack1(b_ack1),
        .rdata(b_rdata), .grant(b_grant), .busy(b_busy),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_select(b_mem_select), .mem_rdata(b_mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Protocol invariants on instance A, checked whenever a strobe is active.
    always @(negedge clk) begin
        if (mem_select) sel_cnt <= sel_cnt + 1;
        if (mem_select || ack0 || ack1) begin
            checks = checks + 1;
            if ((ack0 && ack1) || (mem_select && prev_sel)) begin
                errors = errors + 1;
                $display("FAIL invariant: ack0=%0b ack1=%0b sel=%0b prev_sel=%0b required one-hot ack and no double select",
                         ack0, ack1, mem_select, prev_sel);
            end
        end
        prev_sel <= mem_select;
    end

    // Pops one expected transaction and follows it from select pulse to ack on instance A.
    task automatic observe(input logic [1:0] drop, output int sel_c, output int ack_c);
        exp_t e;
        int   n;
        sel_c = -1;
        ack_c = -1;
        checks = checks + 1;
        if (sb_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL sb_empty: got empty queue required entry");
            return;
        end
        e = sb_q.pop_front();
        n = 0;
        while (!mem_select && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!mem_select) begin
            errors = errors + 1;
            $display("FAIL sel_timeout: got mem_select=0 required 1");
        end else begin
            sel_c = cyc;
            if ({grant, mem_we, mem_addr, mem_wdata} !== {e.port, e.we, e.addr, e.wdata}) begin
                errors = errors + 1;
                $display("FAIL sel_bus: got grant=%0b we=%0b addr=%h wdata=%h required %0b %0b %h %h",
                         grant, mem_we, mem_addr, mem_wdata, e.port, e.we, e.addr, e.wdata);
            end
        end
        @(negedge clk);
        n = 0;
        while (!(ack0 || ack1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks = checks + 1;
        if (!(ack0 || ack1)) begin
            errors = errors + 1;
            $display("FAIL ack_timeout: got no ack required ack%0b", e.port);
        end else begin
            ack_c = cyc;
            if ({ack1, ack0, rdata, mem_addr, mem_we} !== {e.port, ~e.port, e.rdata, e.addr, e.we}) begin
                errors = errors + 1;
                $display("FAIL ack_data: got ack1=%0b ack0=%0b rdata=%h addr=%h we=%0b required %0b %0b %h %h %0b",
                         ack1, ack0, rdata, mem_addr, mem_we, e.port, ~e.port, e.rdata, e.addr, e.we);
            end
        end
        if (drop[0]) req0 = 1'b0;
        if (drop[1]) req1 = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if ({ack1, ack0} !== 2'b00) begin
            errors = errors + 1;
            $display("FAIL ack_width: got %b required 00", {ack1, ack0});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks = checks + 2;
        if ({ack0, ack1, mem_select, busy, grant, mem_we, rdata, mem_addr, mem_wdata} !== 53'h0) begin
            errors = errors + 1;
            $display("FAIL reset_a: got ack=%b sel=%b busy=%b grant=%b we=%b rdata=%h addr=%h wdata=%h required all 0",
                     {ack1, ack0}, mem_select, busy, grant, mem_we, rdata, mem_addr, mem_wdata);
        end
        if ({b_ack0, b_ack1, b_mem_select, b_busy, b_grant, b_mem_we, b_rdata, b_mem_addr, b_mem_wdata} !== 53'h0) begin
            errors = errors + 1;
            $display("FAIL reset_b: got nonzero outputs on latency-3 instance required all 0");
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int k, s, a;
        mem_rdata = 16'h1234;
        addr0 = 16'h0010; wdata0 = 16'h0000; we0 = 1'b0;
        sb_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, rdata: 16'h1234});
        k = cyc + 1;
        req0 = 1'b1;
        observe(2'b01, s, a);
        checks = checks + 1;
        if (s !== k || a !== k + 2) begin
            errors = errors + 1;
            $display("FAIL read_latency: got sel=%0d ack=%0d required sel=%0d ack=%0d", s, a, k, k + 2);
        end
    endtask

    task automatic test_single_write();
        int k, s, a;
        mem_rdata = 16'hDEAD;
        addr1 = 16'hFFFA; wdata1 = 16'h03FF; we1 = 1'b1;
        sb_q.push_back('{port: 1'b1, we: 1'b1, addr: 16'hFFFA, wdata: 16'h03FF, rdata: 16'h1234});
        k = cyc + 1;
        req1 = 1'b1;
        observe(2'b10, s, a);
        checks = checks + 1;
        if (a !== s + 2) begin
            errors = errors + 1;
            $display("FAIL write_latency: got ack=%0d required %0d", a, s + 2);
        end
    endtask

    task automatic test_back_to_back();
        int s[4];
        int a, base;
        mem_rdata = 16'h5555;
        addr0 = 16'h0200; wdata0 = 16'h1111; we0 = 1'b0;
        addr1 = 16'h0300; wdata1 = 16'hA5A5; we1 = 1'b1;
        // Port 1 won last, so contention starts with port 0 and alternates.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0)
                sb_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0200, wdata: 16'h1111, rdata: 16'h5555});
            else
                sb_q.push_back('{port: 1'b1, we: 1'b1, addr: 16'h0300, wdata: 16'hA5A5, rdata: 16'h5555});
        end
        base = sel_cnt;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < 4; i++) observe((i == 3) ? 2'b11 : 2'b00, s[i], a);
        repeat (4) @(negedge clk);
        checks = checks + 1;
        if (sel_cnt - base !== 4) begin
            errors = errors + 1;
            $display("FAIL b2b_count: got %0d select pulses required 4", sel_cnt - base);
        end
        for (int i = 1; i < 4; i++) begin
            checks = checks + 1;
            if (s[i] - s[i-1] !== 4) begin
                errors = errors + 1;
                $display("FAIL b2b_spacing: got %0d cycles required 4", s[i] - s[i-1]);
            end
        end
    endtask

    task automatic test_latency3();
        exp_t e;
        int   ks, ka, n;
        b_mem_rdata = 16'h0000;
        b_addr0 = 16'h0100; b_wdata0 = 16'h0000; b_we0 = 1'b0;
        sb_b.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0100, wdata: 16'h0000, rdata: 16'hBEEF});
        b_req0 = 1'b1;
        n = 0;
        ks = -1;
        ka = -1;
        while (!b_mem_select && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (b_mem_select) ks = cyc;
        @(negedge clk);
        b_mem_rdata = 16'hBEEF;
        n = 0;
        while (!(b_ack0 || b_ack1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (b_ack0 || b_ack1) ka = cyc;
        e = sb_b.pop_front();
        checks = checks + 2;
        if (ks < 0 || ka !== ks + 4) begin
            errors = errors + 1;
            $display("FAIL lat3_timing: got sel=%0d ack=%0d required ack=sel+4", ks, ka);
        end
        if ({b_ack1, b_ack0, b_rdata, b_mem_addr} !== {e.port, ~e.port, e.rdata, e.addr}) begin
            errors = errors + 1;
            $display("FAIL lat3_data: got ack=%b rdata=%h addr=%h required %b %h %h",
                     {b_ack1, b_ack0}, b_rdata, b_mem_addr, {e.port, ~e.port}, e.rdata, e.addr);
        end
        b_req0 = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        int   s, a;
        logic seen_ack;
        addr0 = 16'h0040; we0 = 1'b0;
        req0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (busy !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL wait_busy: got busy=%0b required 1", busy);
        end
        reset = 1'b1;
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        checks = checks + 1;
        if ({ack0, ack1, busy, mem_select} !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL abort_state: got ack0=%0b ack1=%0b busy=%0b sel=%0b required 0000", ack0, ack1, busy, mem_select);
        end
        seen_ack = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_ack = seen_ack | ack0 | ack1;
        end
        checks = checks + 1;
        if (seen_ack !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL abort_ack: got ack after reset required none");
        end
        mem_rdata = 16'h7777;
        addr0 = 16'h0050; wdata0 = 16'h0000; we0 = 1'b0;
        addr1 = 16'h0060; wdata1 = 16'h0000; we1 = 1'b0;
        sb_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0050, wdata: 16'h0000, rdata: 16'h7777});
        req0 = 1'b1;
        req1 = 1'b1;
        observe(2'b11, s, a);
    endtask

    task automatic test_held_off();
        int s0, a0, s1, a1;
        mem_rdata = 16'h2222;
        addr0 = 16'h0060; wdata0 = 16'h0000; we0 = 1'b0;
        addr1 = 16'h0070; wdata1 = 16'h0BAD; we1 = 1'b1;
        sb_q.push_back('{port: 1'b0, we: 1'b0, addr: 16'h0060, wdata: 16'h0000, rdata: 16'h2222});
        sb_q.push_back('{port: 1'b1, we: 1'b1, addr: 16'h0070, wdata: 16'h0BAD, rdata: 16'h2222});
        req0 = 1'b1;
        @(negedge clk);
        req1 = 1'b1;
        observe(2'b01, s0, a0);
        observe(2'b10, s1, a1);
        checks = checks + 1;
        if (s1 !== a0 + 2) begin
            errors = errors + 1;
            $display("FAIL held_off_grant: got sel=%0d required %0d", s1, a0 + 2);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_back_to_back();
        test_latency3();
        test_reset_in_wait();
        test_held_off();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
